// File: rtl/pc_npc_sequencer.sv
// pc_npc_sequencer
// Sequencing controller for the SPARC PC/nPC datapath. Generates the PC/nPC
// load enables and the nPC source select each cycle, implements delayed
// control transfer with the annul bit, honours pipeline stalls and keeps
// fetch frozen for a short boot interval after reset.
module pc_npc_sequencer #(
  parameter int BOOT_CYCLES = 2,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             stall,
  input  logic             ID_branch_instr,
  input  logic             ID_call_instr,
  input  logic             ID_jmpl_instr,
  input  logic             branch_taken,
  input  logic             ID_annul,
  input  logic             ID_ba,
  output logic             pc_le,
  output logic             npc_le,
  output logic [1:0]       npc_sel,
  output logic             if_id_clr,
  output logic             dcti_err,
  output logic [CNT_W-1:0] redirect_cnt
);

  // Elaboration-time guard on the boot interval range.
  if (BOOT_CYCLES < 1 || BOOT_CYCLES > 15) begin : g_boot_range
    $error("pc_npc_sequencer: BOOT_CYCLES must be in 1..15");
  end

  typedef enum logic [1:0] {
    ST_BOOT   = 2'd0,
    ST_RUN    = 2'd1,
    ST_SLOT   = 2'd2,
    ST_SQUASH = 2'd3
  } state_e;

  localparam logic [3:0]       BOOT_INIT = 4'(BOOT_CYCLES - 1);
  localparam logic [1:0]       SEL_SEQ   = 2'b00;
  localparam logic [1:0]       SEL_TA    = 2'b01;
  localparam logic [1:0]       SEL_ALU   = 2'b10;
  localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE   = {{(CNT_W-1){1'b0}}, 1'b1};

  state_e           state_q, state_d;
  logic [3:0]       boot_cnt_q, boot_cnt_d;
  logic             dcti_err_q, dcti_err_d;
  logic [CNT_W-1:0] redir_cnt_q, redir_cnt_d;

  logic       cti;
  logic       annul_slot;
  logic [1:0] redir_sel;
  logic       run_go;
  logic       slot_go;

  // Decode of the instruction sitting in ID: CTI presence, annul of the
  // delay slot and the prioritised redirect source.
  always_comb begin
    cti        = ID_jmpl_instr | ID_call_instr | ID_branch_instr;
    annul_slot = ID_branch_instr & ID_annul & (~branch_taken | ID_ba);
    if (ID_jmpl_instr) begin
      redir_sel = SEL_ALU;
    end else if (ID_call_instr) begin
      redir_sel = SEL_TA;
    end else if (ID_branch_instr && branch_taken) begin
      redir_sel = SEL_TA;
    end else begin
      redir_sel = SEL_SEQ;
    end
    run_go  = (state_q == ST_RUN)  && !stall;
    slot_go = (state_q == ST_SLOT) && !stall;
  end

  // State, boot counter, sticky error and redirect counter registers.
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      state_q     <= ST_BOOT;
      boot_cnt_q  <= BOOT_INIT;
      dcti_err_q  <= 1'b0;
      redir_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      boot_cnt_q  <= boot_cnt_d;
      dcti_err_q  <= dcti_err_d;
      redir_cnt_q <= redir_cnt_d;
    end
  end

  // Next-state logic; a stall in RUN or SLOT freezes everything so a CTI
  // held in ID is resolved only once the stall drops.
  always_comb begin
    state_d    = state_q;
    boot_cnt_d = boot_cnt_q;
    case (state_q)
      ST_BOOT: begin
        if (boot_cnt_q == 4'd0) begin
          state_d = ST_RUN;
        end else begin
          boot_cnt_d = boot_cnt_q - 4'd1;
        end
      end
      ST_RUN: begin
        if (!stall) begin
          if (annul_slot) begin
            state_d = ST_SQUASH;
          end else if (cti) begin
            state_d = ST_SLOT;
          end
        end
      end
      ST_SLOT: begin
        if (!stall) begin
          state_d = ST_RUN;
        end
      end
      ST_SQUASH: begin
        state_d = ST_RUN;
      end
      default: begin
        state_d = ST_BOOT;
      end
    endcase
  end

  // Sticky DCTI-couple flag and saturating count of taken redirects.
  always_comb begin
    dcti_err_d  = dcti_err_q | (slot_go & cti);
    redir_cnt_d = redir_cnt_q;
    if (run_go && (redir_sel != SEL_SEQ) && (redir_cnt_q != CNT_MAX)) begin
      redir_cnt_d = redir_cnt_q + CNT_ONE;
    end
  end

  // Output decode: combinational from state and the current ID inputs.
  always_comb begin
    pc_le     = 1'b0;
    npc_le    = 1'b0;
    npc_sel   = SEL_SEQ;
    if_id_clr = 1'b0;
    case (state_q)
      ST_RUN: begin
        if (!stall) begin
          pc_le     = 1'b1;
          npc_le    = 1'b1;
          npc_sel   = redir_sel;
          if_id_clr = annul_slot;
        end
      end
      ST_SLOT: begin
        if (!stall) begin
          pc_le  = 1'b1;
          npc_le = 1'b1;
        end
      end
      ST_SQUASH: begin
        pc_le  = 1'b1;
        npc_le = 1'b1;
      end
      default: begin
        pc_le     = 1'b0;
        npc_le    = 1'b0;
        npc_sel   = SEL_SEQ;
        if_id_clr = 1'b0;
      end
    endcase
  end

  assign dcti_err     = dcti_err_q;
  assign redirect_cnt = redir_cnt_q;

endmodule
